// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register, its driver and downstream stages.
// Exposes shreg_mode_e, the mode encoding the bit producer uses (HOLD under backpressure).
package shreg_pkg;

    typedef enum logic [1:0] {
        SHREG_HOLD = 2'b00,
        SHREG_SHL  = 2'b01,
        SHREG_SHR  = 2'b10,
        SHREG_LOAD = 2'b11
    } shreg_mode_e;

endpackage

// File: rtl/word_hold_reg.sv
// One-entry valid/ready holding register for packed words.
// Ports: clk, rst (async high), load/data_in (capture), out_data/out_valid/out_ready (handshake).
module word_hold_reg
    import shreg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0] state;

    // The packer never loads while FULL (its bit_ready blocks the last bit),
    // so load only ever happens from EMPTY or in the cycle nothing is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
        end else if (load) begin
            state    <= FULL;
            out_data <= data_in;
        end else if (state == FULL && out_ready) begin
            state <= EMPTY;
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: rtl/serial_word_packer.sv
// Packs a serial bit stream (one bit per accepted bit_valid) into N-bit words.
// Ports: clk, rst, flush, bit_in/bit_valid/bit_ready, out_data/out_valid/out_ready, bit_cnt, err.
module serial_word_packer
    import shreg_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic [N-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] bit_cnt,
    output logic                 err
);

    localparam int CW = $clog2(N);

    if (N < 2) begin : g_bad_n
        $error("serial_word_packer: N must be >= 2");
    end

    logic [N-1:0] acc;
    logic [N-1:0] shifted;
    logic         last;
    logic         accept;
    logic         complete;

    assign last      = (bit_cnt == CW'(N - 1));
    // Registered terms only, so out_ready never reaches bit_ready combinationally.
    assign bit_ready = !(last && out_valid);
    assign accept    = bit_valid && bit_ready && !flush;
    assign complete  = accept && last;

    if (MSB_FIRST) begin : g_msb
        assign shifted = {acc[N-2:0], bit_in};
    end else begin : g_lsb
        assign shifted = {bit_in, acc[N-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            bit_cnt <= '0;
            err     <= 1'b0;
        end else if (flush) begin
            acc     <= '0;
            bit_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (accept) begin
                if (last) begin
                    acc     <= '0;
                    bit_cnt <= '0;
                end else begin
                    acc     <= shifted;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            // A bit offered while we are stalled is lost; remember it.
            if (bit_valid && !bit_ready) begin
                err <= 1'b1;
            end
        end
    end

    word_hold_reg #(
        .W(N)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (complete),
        .data_in  (shifted),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

endmodule

// File: tb/tb_serial_word_packer.sv
// Scoreboard bench for serial_word_packer: MSB-first and LSB-first instances
// share one stimulus stream; a monitor pops expected words on each transfer.
module tb_serial_word_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       bit_in;
    logic       bit_valid;
    logic       out_ready;

    logic       bit_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] bit_cnt;
    logic       err;

    logic       l_bit_ready;
    logic [7:0] l_out_data;
    logic       l_out_valid;
    logic [2:0] l_bit_cnt;
    logic       l_err;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];

    always #5 clk = ~clk;

    serial_word_packer #(.N(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .bit_cnt(bit_cnt), .err(err)
    );

    serial_word_packer #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .flush(flush),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(l_bit_ready),
        .out_data(l_out_data), .out_valid(l_out_valid), .out_ready(out_ready),
        .bit_cnt(l_bit_cnt), .err(l_err)
    );

    function automatic void check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Stream is sent MSB of w first; LSB-first instance sees the mirror.
    function automatic void expect_word(input logic [7:0] w);
        exp_m.push_back(w);
        exp_l.push_back(rev8(w));
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_m.size() == 0) check("msb_unexpected_word", int'(out_data), -1);
            else check("msb_word", int'(out_data), int'(exp_m.pop_front()));
        end
        if (!rst && l_out_valid && out_ready) begin
            if (exp_l.size() == 0) check("lsb_unexpected_word", int'(l_out_data), -1);
            else check("lsb_word", int'(l_out_data), int'(exp_l.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; bit_in = 1'b0;
        bit_valid = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_bit_cnt", int'(bit_cnt), 0);
        check("rst_err", int'(err), 0);
        check("rst_bit_ready", int'(bit_ready), 1);
        tick();
        rst = 1'b0;
        tick();

        // 1/2: A5 back-to-back, one-cycle out_valid, counter walk
        expect_word(8'hA5);
        begin
            logic [7:0] w;
            w = 8'hA5;
            for (int i = 0; i < 8; i++) begin
                check("t1_bit_cnt", int'(bit_cnt), i);
                check("t1_no_valid", int'(out_valid), 0);
                send_bit(w[7-i]);
            end
        end
        check("t1_valid_after_8", int'(out_valid), 1);
        check("t1_data", int'(out_data), 8'hA5);
        check("t2_lsb_data", int'(l_out_data), 8'hA5);
        check("t1_cnt_wrap", int'(bit_cnt), 0);
        tick();
        check("t1_valid_one_cycle", int'(out_valid), 0);

        // 3: backpressure
        out_ready = 1'b0;
        expect_word(8'h3C);
        send_word(8'h3C);
        expect_word(8'hC3);
        for (int i = 7; i >= 1; i--) send_bit(1'((8'hC3 >> i) & 1));
        check("t3_cnt7", int'(bit_cnt), 7);
        check("t3_bit_ready_low", int'(bit_ready), 0);
        check("t3_hold_data", int'(out_data), 8'h3C);
        tick();
        check("t3_data_stable", int'(out_data), 8'h3C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3_bit_ready_high", int'(bit_ready), 1);
        check("t3_drained", int'(out_valid), 0);
        send_bit(1'b1);
        check("t3_next_data", int'(out_data), 8'hC3);
        check("t3_err_clear", int'(err), 0);
        out_ready = 1'b1;
        tick();

        // 4: violation sets err, dropped bit absent
        out_ready = 1'b0;
        expect_word(8'h0F);
        send_word(8'h0F);
        expect_word(8'hF0);
        for (int i = 7; i >= 1; i--) send_bit(1'((8'hF0 >> i) & 1));
        bit_in = 1'b1; bit_valid = 1'b1;
        tick();
        tick();
        bit_valid = 1'b0;
        check("t4_err_set", int'(err), 1);
        check("t4_cnt_frozen", int'(bit_cnt), 7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_bit(1'b0);
        check("t4_word", int'(out_data), 8'hF0);
        out_ready = 1'b1;
        tick();
        check("t4_err_sticky", int'(err), 1);
        send_bit(1'b1);
        send_bit(1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_flush_err", int'(err), 0);
        check("t4_flush_cnt", int'(bit_cnt), 0);

        // 5: flush discards partial, flush beats bit_valid
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check("t5_cnt3", int'(bit_cnt), 3);
        flush = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        tick();
        flush = 1'b0; bit_valid = 1'b0;
        check("t5_flush_bit_ignored", int'(bit_cnt), 0);
        expect_word(8'h00);
        send_word(8'h00);
        check("t5_no_residue", int'(out_data), 8'h00);
        tick();

        // 6: reset mid-word with a word held
        out_ready = 1'b0;
        send_word(8'h5A);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("t6_cnt5", int'(bit_cnt), 5);
        check("t6_held", int'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", int'(out_valid), 0);
        check("t6_rst_data", int'(out_data), 0);
        check("t6_rst_cnt", int'(bit_cnt), 0);
        out_ready = 1'b1;
        expect_word(8'hFF);
        send_word(8'hFF);
        check("t6_ff", int'(out_data), 8'hFF);
        tick();
        tick();

        check("sb_msb_empty", exp_m.size(), 0);
        check("sb_lsb_empty", exp_l.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
